// File: rtl/div_seq_pkg.sv
// div_seq_pkg
// Shared definitions for the iterative divider sequencer:
//   - div_state_e : sequencer state encoding (2 bits)
//   - result-ready, start and stall level constants
//   - DivCntW     : width of the iteration counter
//   - div_stall_f : stall request as a function of state and EX request
package div_seq_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic Stop              = 1'b1;
  localparam logic NoStop            = 1'b0;

  localparam int DivCntW = 6;

  // END deliberately does not stall, so EX advances in the same cycle it
  // picks up the result.
  function automatic logic div_stall_f(input div_state_e st,
                                       input logic start,
                                       input logic annul);
    logic stall;
    case (st)
      DivFree:   stall = ((start == DivStart) && !annul) ? Stop : NoStop;
      DivOn:     stall = Stop;
      DivByZero: stall = Stop;
      DivEnd:    stall = NoStop;
      default:   stall = NoStop;
    endcase
    return stall;
  endfunction

endpackage

// File: rtl/div_seq_step.sv
// div_step
// One combinational radix-2 restoring-division iteration.
// The working register holds {partial remainder, remaining dividend bits /
// quotient bits}. The iteration shifts left by one, trial-subtracts the
// divisor from the upper part and shifts in a quotient bit of 1 when the
// difference is non-negative.
// Ports:
//   work_i    : working register before the iteration (2*WIDTH+1 bits)
//   divisor_i : divisor magnitude (WIDTH bits)
//   work_o    : working register after the iteration (2*WIDTH+1 bits)
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]  work_i,
  input  logic [WIDTH-1:0]  divisor_i,
  output logic [2*WIDTH:0]  work_o
);

  // Upper part after the left shift, kept one bit wider than needed so the
  // subtraction's borrow lands in a dedicated sign bit.
  logic [WIDTH+1:0] upper_s;
  logic [WIDTH+1:0] diff_s;
  logic             neg_s;

  // Shift, trial subtract and quotient-bit insertion.
  always_comb begin
    upper_s = work_i[2*WIDTH:WIDTH-1];
    diff_s  = upper_s - {2'b00, divisor_i};
    neg_s   = diff_s[WIDTH+1];
    if (neg_s) begin
      work_o = {upper_s[WIDTH:0], work_i[WIDTH-2:0], 1'b0};
    end else begin
      work_o = {diff_s[WIDTH:0], work_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// div_seq
// Iterative radix-2 divider sequencer for the EX stage. Accepts a divide
// request, runs WIDTH shift-subtract iterations through div_step and returns
// {remainder, quotient}. Holds the pipeline through stallreq_o while busy.
// Build option: define DIV_ZERO_FAST_EN to short-cut a zero divisor through
// the BYZERO state (result 0); otherwise a zero divisor runs the full
// sequence and returns the raw algorithm output.
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous, active-low reset
//   start_i    : divide request, held by EX until ready_o
//   annul_i    : abort (pipeline flush)
//   signed_i   : 1 = signed divide, 0 = unsigned
//   opdata1_i  : dividend
//   opdata2_i  : divisor
//   result_o   : {remainder, quotient}, registered
//   ready_o    : result valid pulse, registered
//   stallreq_o : stall request to pipeline control
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 annul_i,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 stallreq_o
);

  localparam logic [DivCntW-1:0] CntLast = DivCntW'(WIDTH - 1);

  div_state_e          state_q, state_d;
  logic [DivCntW-1:0]  cnt_q, cnt_d;
  logic [2*WIDTH:0]    work_q, work_d;
  logic [WIDTH-1:0]    divisor_q, divisor_d;
  logic                neg_quot_q, neg_quot_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]  result_q, result_d;
  logic                ready_q, ready_d;
  logic [2*WIDTH:0]    step_s;

  function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
    return {WIDTH{1'b0}} - v;
  endfunction

  function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v,
                                             input logic sgn);
    return (sgn && v[WIDTH-1]) ? neg_f(v) : v;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .work_i    (work_q),
    .divisor_i (divisor_q),
    .work_o    (step_s)
  );

  // Next-state, datapath and output computation for the sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = DivResultNotReady;
    case (state_q)
      DivFree: begin
        if (annul_i) begin
          state_d  = DivFree;
          result_d = {(2*WIDTH){1'b0}};
        end else if (start_i == DivStart) begin
          // Work on magnitudes; signs are folded back in on the last step.
          divisor_d  = mag_f(opdata2_i, signed_i);
          work_d     = {{(WIDTH+1){1'b0}}, mag_f(opdata1_i, signed_i)};
          neg_quot_d = signed_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          neg_rem_d  = signed_i && opdata1_i[WIDTH-1];
          cnt_d      = {DivCntW{1'b0}};
          result_d   = {(2*WIDTH){1'b0}};
`ifdef DIV_ZERO_FAST_EN
          if (opdata2_i == {WIDTH{1'b0}}) begin
            state_d = DivByZero;
          end else begin
            state_d = DivOn;
          end
`else
          state_d = DivOn;
`endif
        end else begin
          state_d = DivFree;
        end
      end
      DivByZero: begin
        if (annul_i) begin
          state_d  = DivFree;
          result_d = {(2*WIDTH){1'b0}};
        end else begin
          state_d  = DivEnd;
          result_d = {(2*WIDTH){1'b0}};
          ready_d  = DivResultReady;
        end
      end
      DivOn: begin
        if (annul_i) begin
          state_d  = DivFree;
          result_d = {(2*WIDTH){1'b0}};
        end else begin
          work_d = step_s;
          cnt_d  = cnt_q + {{(DivCntW-1){1'b0}}, 1'b1};
          if (cnt_q == CntLast) begin
            // Result is registered on entry to END so it is valid there.
            state_d  = DivEnd;
            result_d = {neg_rem_q  ? neg_f(step_s[2*WIDTH-1:WIDTH]) : step_s[2*WIDTH-1:WIDTH],
                        neg_quot_q ? neg_f(step_s[WIDTH-1:0])       : step_s[WIDTH-1:0]};
            ready_d  = DivResultReady;
          end else begin
            state_d = DivOn;
          end
        end
      end
      DivEnd: begin
        state_d = DivFree;
        if (annul_i) begin
          result_d = {(2*WIDTH){1'b0}};
        end else begin
          result_d = result_q;
        end
      end
      default: begin
        state_d  = DivFree;
        result_d = {(2*WIDTH){1'b0}};
      end
    endcase
  end

  // Sequencer state, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DivFree;
      cnt_q      <= {DivCntW{1'b0}};
      work_q     <= {(2*WIDTH+1){1'b0}};
      divisor_q  <= {WIDTH{1'b0}};
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= {(2*WIDTH){1'b0}};
      ready_q    <= DivResultNotReady;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  // Stall is combinational so EX sees it in the accept cycle; gated by reset.
  assign stallreq_o = rst && div_stall_f(state_q, start_i, annul_i);

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int n_assert = 0;
  int n_fail   = 0;

  div_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .annul_i    (annul_i),
    .signed_i   (signed_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, with the zero-divisor behaviour of
  // the selected build.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
`ifdef DIV_ZERO_FAST_EN
      return 64'd0;
`else
      // Raw algorithm: all-ones quotient, remainder = |a|, then sign fix-ups.
      if (!sgn) return {a, 32'hFFFF_FFFF};
      else      return {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
`endif
    end
    if (!sgn) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int exp_latency(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    if (b == 32'd0) return 2;
`endif
    return 33;
  endfunction

  // Called #1 after a rising edge with the DUT idle; that cycle is cycle 0.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn, input string tag);
    logic [63:0] exp;
    int lat, ready_cyc, stall_bad;
    exp       = ref_div(a, b, sgn);
    lat       = exp_latency(b);
    ready_cyc = -1;
    stall_bad = 0;
    start_i   = 1'b1;
    annul_i   = 1'b0;
    signed_i  = sgn;
    opdata1_i = a;
    opdata2_i = b;
    #1;
    check({tag, "_stall_accept"}, {63'd0, stallreq_o}, 64'd1);
    for (int c = 1; c <= 40 && ready_cyc < 0; c++) begin
      @(posedge clk); #1;
      if (ready_o === 1'b1) begin
        ready_cyc = c;
        check({tag, "_stall_end"}, {63'd0, stallreq_o}, 64'd0);
        check({tag, "_result"}, result_o, exp);
        start_i = 1'b0;
      end else begin
        if (stallreq_o !== 1'b1) stall_bad++;
        // Operands after acceptance must not matter.
        opdata1_i = $urandom;
        opdata2_i = $urandom;
      end
    end
    start_i = 1'b0;
    check({tag, "_latency"}, 64'(ready_cyc), 64'(lat));
    check({tag, "_stall_busy_gaps"}, 64'(stall_bad), 64'd0);
    @(posedge clk); #1;
    check({tag, "_ready_pulse"}, {63'd0, ready_o}, 64'd0);
    check({tag, "_result_hold"}, result_o, exp);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    rst       = 1'b0;
    start_i   = 1'b1;
    annul_i   = 1'b0;
    signed_i  = 1'b0;
    opdata1_i = 32'd5;
    opdata2_i = 32'd1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", result_o, 64'd0);
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_stall", {63'd0, stallreq_o}, 64'd0);
    rst     = 1'b1;
    start_i = 1'b0;
    @(posedge clk); #1;
    check("idle_stall", {63'd0, stallreq_o}, 64'd0);

    run_div(32'd100, 32'd7, 1'b0, "udiv_100_7");

    // Reset while a result is held clears it immediately.
    rst = 1'b0;
    #1;
    check("rst_held_result", result_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "sdiv_m7_2");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "sdiv_ovf");
    run_div(32'h0000_1234, 32'd0, 1'b0, "udiv_zero");
    run_div(32'hFFFF_FFF0, 32'd0, 1'b1, "sdiv_zero");

    // Annul in the middle of the iterations.
    start_i   = 1'b1;
    signed_i  = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    check("annul_ready", {63'd0, ready_o}, 64'd0);
    check("annul_stall", {63'd0, stallreq_o}, 64'd0);
    check("annul_result", result_o, 64'd0);
    @(posedge clk); #1;
    check("annul_ready_c12", {63'd0, ready_o}, 64'd0);
    run_div(32'd12345, 32'd67, 1'b0, "after_annul");

    // Start and annul together in FREE: no accept.
    start_i   = 1'b1;
    annul_i   = 1'b1;
    opdata1_i = 32'd50;
    opdata2_i = 32'd5;
    #1;
    check("sim_stall", {63'd0, stallreq_o}, 64'd0);
    @(posedge clk); #1;
    start_i = 1'b0;
    annul_i = 1'b0;
    #1;
    check("sim_no_accept_stall", {63'd0, stallreq_o}, 64'd0);
    check("sim_no_accept_result", result_o, 64'd0);
    @(posedge clk); #1;
    check("sim_no_ready", {63'd0, ready_o}, 64'd0);

    // Reset in the middle of an operation.
    start_i   = 1'b1;
    signed_i  = 1'b1;
    opdata1_i = 32'hFFFF_0000;
    opdata2_i = 32'd9;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_result", result_o, 64'd0);
    check("midrst_ready", {63'd0, ready_o}, 64'd0);
    check("midrst_stall", {63'd0, stallreq_o}, 64'd0);
    @(posedge clk); #1;
    rst     = 1'b1;
    start_i = 1'b0;
    @(posedge clk); #1;
    check("midrst_free_stall", {63'd0, stallreq_o}, 64'd0);
    check("midrst_free_ready", {63'd0, ready_o}, 64'd0);
    run_div(32'd77, 32'd10, 1'b0, "after_rst");

    // Randomized operations.
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = $urandom;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
      s = 1'($urandom_range(0, 1));
      run_div(a, b, s, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Iterative radix-2 divider sequencer for the EX stage. It accepts a 32-bit divide request from EX, runs a 32-iteration shift-subtract sequence, and returns a 64-bit {remainder, quotient} result. It holds the pipeline via `stallreq_o` while busy. `stallreq_o` feeds the pipeline controller's EX stall request, which produces the stall bus. `annul_i` comes from the pipeline flush.

## Interface
- `WIDTH`, default 32: operand width; result is 2*WIDTH.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `start_i` input 1: divide request from EX; held high by EX until `ready_o`.
- `annul_i` input 1: abort current operation (pipeline flush).
- `signed_i` input 1: 1 = DIV (two's complement), 0 = DIVU.
- `opdata1_i` input WIDTH: dividend.
- `opdata2_i` input WIDTH: divisor.
- `result_o` output 2*WIDTH: {remainder[63:32], quotient[31:0]}; HI = remainder, LO = quotient.
- `ready_o` output 1: result valid, one-cycle pulse.
- `stallreq_o` output 1: stall request to pipeline control; `Stop` when high.

## Operation
- States: FREE, BYZERO, ON, END; registered and encoded in 2 bits.
- FREE:
  - `annul_i` high → stay FREE; annul wins over a simultaneous start.
  - Else `start_i` high → capture operands, take magnitudes when `signed_i`, record sign bits, clear counter → ON.
  - With `DIV_ZERO_FAST_EN` defined, a zero divisor goes → BYZERO instead of ON.
- ON:
  - One iteration per cycle on a 2*WIDTH+1 working register: shift left 1, trial-subtract the divisor from the upper half, set the quotient bit on non-negative.
  - A 6-bit counter runs 0..31; after the iteration at count 31 → END.
- BYZERO: → END, result forced to 0.
- END:
  - Apply sign fix-ups when `signed_i`: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - Drive `result_o`, pulse `ready_o`, → FREE unconditionally.
- `annul_i` in ON/BYZERO/END → FREE next cycle, no `ready_o`, `result_o` cleared.
- `start_i` outside FREE is ignored. Operands are sampled only at acceptance; later operand changes have no effect.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0, which is the natural wrap of the negation.
- All arithmetic is modulo 2^WIDTH per half; no overflow flag.

## Timing
- Reset values: state FREE, counter 0, `result_o` 0, `ready_o` 0.
- `stallreq_o` is combinational: (FREE && `start_i` && !`annul_i`) || ON || BYZERO. It is forced 0 while `rst` is low, and 0 in END so EX advances in the same cycle it captures the result.
- Latency: accept at cycle 0, ON in cycles 1..32, END in cycle 33 with `result_o` and `ready_o` valid. The next accept is possible at cycle 34.
- Zero-divisor fast path: accept at cycle 0, BYZERO in cycle 1, END in cycle 2.
- `result_o` holds its value until the next accept or an annul. `ready_o` is high only in END.
- Reset asserted mid-operation: immediate return to FREE, outputs at reset values, no result.

## Configuration
- `DIV_ZERO_FAST_EN`:
  - Defined: zero divisor takes the BYZERO path; result 64'h0 in 3 cycles total.
  - Undefined: BYZERO is unreachable and a zero divisor runs the full 32 iterations with the raw algorithm output, including fix-ups. Unsigned gives quotient 0xFFFFFFFF, remainder = dividend.

## Structure
- Shared package / `lib/defines.vh`: state encodings `DivFree`, `DivByZero`, `DivOn`, `DivEnd`; `DivResultReady`/`DivResultNotReady`; `DivStart`/`DivStop`; existing `Stop`/`NoStop`.
- One sub-module: `div_step`, a combinational single iteration (shift, trial subtract, quotient bit). The sequencer owns the state, counter and sign fix-ups.

## Test plan
- Unsigned 100 / 7: accept at cycle 0 → `ready_o` at cycle 33, `result_o` = {32'd2, 32'd14}; `stallreq_o` high cycles 0..32, low at 33.
- Signed -7 / 2 (0xFFFFFFF9 / 2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Divide by zero, unsigned 0x1234 / 0:
  - Macro defined → `ready_o` at cycle 2, result 0.
  - Macro undefined → cycle 33, result {0x1234, 0xFFFFFFFF}.
- `annul_i` at cycle 10 of ON → FREE at cycle 11, `ready_o` never pulses, `stallreq_o` low, `result_o` 0; a new start at cycle 12 completes normally.
- Simultaneous `start_i` and `annul_i` in FREE → no accept, `stallreq_o` 0. `rst` pulsed low at cycle 15 → all outputs 0 immediately, FREE after release.
